// File: rtl/id_hazard_sequencer.sv
// id_hazard_sequencer: decode-stage sequencer owning ID/EX, handling load-use stalls, redirect flushes and memory freezes.
// Optional performance counters enabled by defining HAZARD_PERF_EN.
module id_hazard_sequencer #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [11:0]      id_controls,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_redirect,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             ex_valid,
   output logic [11:0]      ex_controls,
   output logic [4:0]       ex_rd,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cycles
);
   typedef enum logic {RUN, FLUSH} state_t;
   typedef enum logic [1:0] {ADVANCE, BUBBLE, HOLD} act_t;
   localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);
   state_t state, state_nx;
   act_t act;
   logic [2:0] cnt, cnt_nx;
   logic pend, pend_nx, load_use, redir;
   assign load_use = id_valid & ex_valid & ex_controls[11] & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
   assign redir = ex_redirect | pend;
   // A redirect seen while memory is busy is parked in pend and applied once the freeze lifts.
   always_comb begin
      act = ADVANCE;
      pc_write = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      state_nx = state;
      cnt_nx = cnt;
      pend_nx = pend;
      if (mem_busy) begin
         act = HOLD;
         pc_write = 1'b0;
         ifid_write = 1'b0;
         pend_nx = pend | ex_redirect;
      end else if (redir) begin
         act = BUBBLE;
         ifid_flush = 1'b1;
         pend_nx = 1'b0;
         state_nx = (RELOAD != 3'd0) ? FLUSH : RUN;
         cnt_nx = RELOAD;
      end else if (state == FLUSH) begin
         act = BUBBLE;
         ifid_flush = 1'b1;
         cnt_nx = cnt - 3'd1;
         state_nx = (cnt == 3'd1) ? RUN : FLUSH;
      end else if (load_use) begin
         act = BUBBLE;
         pc_write = 1'b0;
         ifid_write = 1'b0;
      end
      if (reset) begin
         pc_write = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt <= 3'd0;
         pend <= 1'b0;
         ex_valid <= 1'b0;
         ex_controls <= 12'd0;
         ex_rd <= 5'd0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         pend <= pend_nx;
         if (act == ADVANCE) begin
            ex_valid <= id_valid;
            ex_controls <= id_controls;
            ex_rd <= id_rd;
         end else if (act == BUBBLE) begin
            ex_valid <= 1'b0;
            ex_controls <= 12'd0;
            ex_rd <= 5'd0;
         end
      end
   end
`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_q, flush_q;
   logic stall_ev;
   assign stall_ev = mem_busy | ((act == BUBBLE) & ~ifid_flush);
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_ev && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
         if (ifid_flush && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
      end
   end
   assign stall_cycles = stall_q;
   assign flush_cycles = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_cycles = '0;
`endif
endmodule

// File: doc/id_hazard_sequencer.md
Name: id_hazard_sequencer

Overview:
- Sequences the decode stage: owns the ID/EX control register and decides each cycle whether decode advances, holds, or is replaced by a bubble.
- Detects load-use hazards, applies EX-stage redirects (taken branch/jump) as IF/ID flushes, and freezes the front end while data memory is busy.
- Sits between the decode control word (12-bit controls, rs/rd fields) and the EX stage. Drives PC and IF/ID enables.

Parameters:
- FLUSH_CYCLES, 1: number of consecutive cycles IF/ID is flushed after a redirect (1..7).
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  IF/ID holds a real instruction.
- id_controls  in  12  decode control word {mem_read[11], mem_write[10], alu_src[9], mem_to_reg[8:7], alu_op[6:3], reg_write[2], jump[1:0]}.
- id_rs1, id_rs2, id_rd  in  5 each  register fields of the decoding instruction.
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads rs1/rs2.
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle.
- mem_busy  in  1  data memory stalls the pipeline.
- pc_write  out  1  PC may update.
- ifid_write  out  1  IF/ID may load.
- ifid_flush  out  1  IF/ID loads a NOP/invalid.
- ex_valid  out  1  registered; ID/EX holds a real instruction.
- ex_controls  out  12  registered control word for EX.
- ex_rd  out  5  registered destination register.
- stall_cycles, flush_cycles  out  CNT_W each  performance counters (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high):
  - ex_valid=0, ex_controls=0, ex_rd=0, state=RUN, flush counter=0, pending_redirect=0.
  - While reset is high: pc_write=0, ifid_write=0, ifid_flush=1.
- ID/EX update each cycle takes exactly one action:
  - ADVANCE: load id_valid, id_controls, id_rd.
  - BUBBLE: load ex_valid=0, ex_controls=0, ex_rd=0.
  - HOLD: keep the current values.
- Load-use hazard, combinational: id_valid & ex_valid & ex_controls[11] & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- States:
  - RUN, in priority order:
    - mem_busy: HOLD, pc_write=0, ifid_write=0, ifid_flush=0. If ex_redirect is also high, set pending_redirect.
    - ex_redirect or pending_redirect (mem not busy): BUBBLE, ifid_flush=1, pc_write=1, clear pending. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1.
    - load-use: BUBBLE, pc_write=0, ifid_write=0. The next cycle re-evaluates; the hazard clears because EX now holds a bubble. Exactly one bubble is inserted per load-use.
    - else: ADVANCE, pc_write=1, ifid_write=1, ifid_flush=0.
  - FLUSH:
    - Each cycle: BUBBLE, ifid_flush=1, pc_write=1, counter decrements. At counter==1, return to RUN.
    - mem_busy in FLUSH: HOLD, counter frozen, all enables 0.
    - A new ex_redirect in FLUSH reloads the counter to FLUSH_CYCLES-1.
- ex_redirect has priority over load-use in the same cycle; the hazarding instruction is squashed.
- pc_write and ifid_write are never 1 while ifid_flush=1 and mem_busy=1.
- Single-cycle outputs are combinational from state and inputs; no extra latency. ex_* update one cycle after the decision.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with load-use BUBBLE or mem_busy HOLD (not during reset).
  - flush_cycles increments on every cycle with ifid_flush=1 outside reset.
  - Both saturate at all-ones and reset to 0.
- Undefined: both ports tied to 0 and no counter logic is generated.

Test Plan:
- Reset held 2 cycles, then id_valid=1, id_controls=12'h014, id_rd=5 → during reset pc_write=0, ifid_flush=1; first cycle after reset ex_controls=12'h014, ex_rd=5, ex_valid=1.
- Load to x7 in EX (ex_controls[11]=1, ex_rd=7), ID uses rs2=7 → one cycle with pc_write=0, ifid_write=0; next ex_valid=0, ex_controls=0; the following cycle ADVANCE with the held instruction.
- Load in EX with ex_rd=0, ID rs1=0 → no stall, ADVANCE.
- ex_redirect=1 coincident with load-use, FLUSH_CYCLES=2 → ifid_flush=1 for 2 consecutive cycles, two bubbles into EX, no stall cycle.
- mem_busy=1 for 3 cycles with ex_redirect pulsed in the first → ex_* frozen, enables 0 for 3 cycles; the cycle after busy drops, ifid_flush=1 (pending redirect applied).
- HAZARD_PERF_EN defined: one load-use plus 3 mem_busy cycles plus one redirect (FLUSH_CYCLES=1) → stall_cycles=4, flush_cycles=1.
